// File: rtl/reg16_write_arbiter_if.sv
// Write-request bundle between the requesters (master) and the reg16 write arbiter (slave).
interface reg16_write_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 16
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        ack;

  modport master (output req, output req_data, input ack);
  modport slave  (input req, input req_data, output ack);
endinterface

// File: rtl/reg16_write_arbiter.sv
// Round-robin arbiter that serialises N_REQ write requests into single-cycle loads
// of a shared reg16, returning a one-cycle ack per completed write.
module reg16_write_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ID_W   = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  reg16_write_arbiter_if.slave bus,
  output logic [DATA_W-1:0]   reg_in,
  output logic                reg_load,
  output logic [ID_W-1:0]     grant_id,
  output logic                busy,
  output logic [15:0]         wr_count
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, LOAD, ACK} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [DATA_W-1:0] data_q;

  logic              win_vld;
  logic [ID_W-1:0]   win_id;
  logic [DATA_W-1:0] win_data;

  // First set req bit searching upward from rr_ptr, wrapping at N_REQ-1
  always_comb begin : pick
    logic [31:0]     idx;
    logic [ID_W-1:0] idx_id;
    win_vld  = 1'b0;
    win_id   = '0;
    win_data = '0;
    idx      = '0;
    idx_id   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_id = ID_W'(idx);
      if (!win_vld && bus.req[idx_id]) begin
        win_vld  = 1'b1;
        win_id   = idx_id;
        win_data = DATA_W'(bus.req_data >> (idx * DATA_W));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      bus.ack  <= '0;
      reg_load <= 1'b0;
      reg_in   <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      wr_count <= '0;
      rr_ptr   <= '0;
      data_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            data_q   <= win_data;
            grant_id <= win_id;
            reg_in   <= win_data;
            reg_load <= 1'b1;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          reg_load <= 1'b0;
          reg_in   <= data_q;
          bus.ack  <= N_REQ'(1) << grant_id;
          state    <= ACK;
        end
        ACK: begin
          bus.ack  <= '0;
          busy     <= 1'b0;
          wr_count <= wr_count + CNT_W'(1);
          // Modulo wrap keeps rr_ptr in range for non-power-of-two N_REQ
          rr_ptr   <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
          state    <= IDLE;
        end
        default: begin
          bus.ack  <= '0;
          reg_load <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg16_write_arbiter.sv
// Directed bench for reg16_write_arbiter with a behavioural reg16 on the load port.
module tb_reg16_write_arbiter;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ID_W   = 2;

  logic              clk;
  logic              reset_n;
  logic [DATA_W-1:0] reg_in;
  logic              reg_load;
  logic [ID_W-1:0]   grant_id;
  logic              busy;
  logic [15:0]       wr_count;
  logic [DATA_W-1:0] reg16_q;
  logic [15:0]       exp_cnt;

  int n_tests;
  int n_fail;

  reg16_write_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  reg16_write_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .reg_in   (reg_in),
    .reg_load (reg_load),
    .grant_id (grant_id),
    .busy     (busy),
    .wr_count (wr_count)
  );

  // reg16 has no reset: it captures whenever load is high
  always_ff @(posedge clk) begin
    if (reg_load) reg16_q <= reg_in;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One full write starting the cycle after the grant edge; req is updated at the ack cycle
  task automatic xfer(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] data,
                      input logic [N_REQ-1:0] req_after_ack);
    @(negedge clk);
    check("load_pulse", 32'(reg_load), 32'd1);
    check("load_data",  32'(reg_in),   32'(data));
    check("grant_id",   32'(grant_id), 32'(id));
    check("busy_load",  32'(busy),     32'd1);
    check("ack_load",   32'(bus.ack),  32'd0);
    @(negedge clk);
    check("ack_onehot", 32'(bus.ack),  32'(4'b0001 << id));
    check("load_ack",   32'(reg_load), 32'd0);
    check("busy_ack",   32'(busy),     32'd1);
    check("regin_ack",  32'(reg_in),   32'(data));
    bus.req = req_after_ack;
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    check("ack_clear",  32'(bus.ack),  32'd0);
    check("busy_idle",  32'(busy),     32'd0);
    check("reg16_out",  32'(reg16_q),  32'(data));
    check("wr_count",   32'(wr_count), 32'(exp_cnt));
  endtask

  initial begin
    logic [DATA_W-1:0] dtab [N_REQ];
    n_tests = 0;
    n_fail  = 0;
    exp_cnt = '0;
    dtab[0] = 16'h1111;
    dtab[1] = 16'h2222;
    dtab[2] = 16'h3333;
    dtab[3] = 16'h4444;

    // Reset held with all requesting
    reset_n      = 1'b0;
    bus.req      = 4'b1111;
    bus.req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    repeat (2) begin
      @(negedge clk);
      check("rst_ack",   32'(bus.ack),  32'd0);
      check("rst_load",  32'(reg_load), 32'd0);
      check("rst_busy",  32'(busy),     32'd0);
      check("rst_count", 32'(wr_count), 32'd0);
      check("rst_regin", 32'(reg_in),   32'd0);
    end
    reset_n = 1'b1;

    // Round-robin with all requesting: 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      xfer(ID_W'(i % 4), dtab[i % 4], (i == 4) ? 4'b0000 : 4'b1111);
    end

    // Single write from requester 2 (rr_ptr is 1)
    bus.req = 4'b0100;
    bus.req_data[32 +: 16] = 16'h0912;
    xfer(2'd2, 16'h0912, 4'b0000);

    // Data changed and req dropped during LOAD must not affect the write
    bus.req = 4'b0010;
    bus.req_data[16 +: 16] = 16'hFFFF;
    @(negedge clk);
    check("stab_load",  32'(reg_load), 32'd1);
    check("stab_grant", 32'(grant_id), 32'd1);
    bus.req_data[16 +: 16] = 16'h0001;
    bus.req = 4'b0000;
    @(negedge clk);
    check("stab_ack",   32'(bus.ack),  32'(4'b0010));
    check("stab_regin", 32'(reg_in),   32'hFFFF);
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    check("stab_reg16", 32'(reg16_q),  32'hFFFF);
    check("stab_count", 32'(wr_count), 32'(exp_cnt));

    // rr_ptr=2 with req 0 and 1: search wraps to 0, then 1
    bus.req = 4'b0011;
    bus.req_data[0 +: 16]  = 16'hA0A0;
    bus.req_data[16 +: 16] = 16'hB1B1;
    xfer(2'd0, 16'hA0A0, 4'b0011);
    xfer(2'd1, 16'hB1B1, 4'b0001);
    // Lone requester held high is granted every 3 cycles
    xfer(2'd0, 16'hA0A0, 4'b0001);
    xfer(2'd0, 16'hA0A0, 4'b0000);

    // Reset on the edge ending LOAD: reg16 still captures, no ack, count cleared
    bus.req = 4'b1000;
    bus.req_data[48 +: 16] = 16'hABCD;
    @(negedge clk);
    check("mrst_load",  32'(reg_load), 32'd1);
    check("mrst_grant", 32'(grant_id), 32'd3);
    reset_n = 1'b0;
    bus.req = 4'b0000;
    repeat (3) begin
      @(negedge clk);
      check("mrst_ack",   32'(bus.ack),  32'd0);
      check("mrst_count", 32'(wr_count), 32'd0);
      check("mrst_reg16", 32'(reg16_q),  32'hABCD);
      check("mrst_busy",  32'(busy),     32'd0);
    end
    reset_n = 1'b1;
    exp_cnt = '0;

    // Counter wrap FFFF -> 0000; first grant after reset from rr_ptr=0 reaches id 2
    force dut.wr_count = 16'hFFFF;
    @(negedge clk);
    release dut.wr_count;
    exp_cnt = 16'hFFFF;
    bus.req = 4'b0100;
    bus.req_data[32 +: 16] = 16'h5A5A;
    xfer(2'd2, 16'h5A5A, 4'b0000);
    check("wrap_zero", 32'(wr_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
